// File: rtl/bc_io_interrupt_ctrl.sv
// Basic Computer I/O and interrupt block: FGI/FGO flags, INPR/OUTR, IEN, R,
// register-I/O instruction execution and the RT0..RT2 interrupt-cycle sequencer.
module bc_io_interrupt_ctrl #(
  parameter int CHAR_W   = 8,
  parameter int ADDR_W   = 12,
  parameter int RET_ADDR = 0,
  parameter int ISR_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_exec,
  input  logic [5:0]        io_op,
  input  logic [CHAR_W-1:0] ac_lo,
  input  logic              fetch_busy,
  input  logic              instr_boundary,
  input  logic              kb_valid,
  input  logic [CHAR_W-1:0] kb_data,
  input  logic              prn_ack,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              r_flag,
  output logic [CHAR_W-1:0] inpr,
  output logic [CHAR_W-1:0] outr,
  output logic              prn_req,
  output logic              ac_load_inpr,
  output logic              skip_pc,
  output logic              irq_active,
  output logic              irq_ar_load,
  output logic [ADDR_W-1:0] irq_ar_value,
  output logic              irq_tr_load_pc,
  output logic              irq_mem_write,
  output logic              irq_pc_load,
  output logic [ADDR_W-1:0] irq_pc_value,
  output logic              kb_overrun
);

  typedef enum logic [1:0] {IDLE, RT0, RT1, RT2} irq_state_t;

  irq_state_t        state_q, state_d;
  logic              fgi_q, fgi_d;
  logic              fgo_q, fgo_d;
  logic              ien_q, ien_d;
  logic              r_q, r_d;
  logic              ovr_q, ovr_d;
  logic [CHAR_W-1:0] inpr_q, inpr_d;
  logic [CHAR_W-1:0] outr_q, outr_d;

  logic io_valid;
  logic op_inp, op_out, op_ski, op_sko, op_ion, op_iof;

  assign io_valid = io_exec & (state_q == IDLE);
  assign op_inp   = io_valid & io_op[5];
  assign op_out   = io_valid & io_op[4];
  assign op_ski   = io_valid & io_op[3];
  assign op_sko   = io_valid & io_op[2];
  assign op_ion   = io_valid & io_op[1];
  assign op_iof   = io_valid & io_op[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fgi_q   <= 1'b0;
      fgo_q   <= 1'b1;
      ien_q   <= 1'b0;
      r_q     <= 1'b0;
      ovr_q   <= 1'b0;
      inpr_q  <= '0;
      outr_q  <= '0;
    end else begin
      state_q <= state_d;
      fgi_q   <= fgi_d;
      fgo_q   <= fgo_d;
      ien_q   <= ien_d;
      r_q     <= r_d;
      ovr_q   <= ovr_d;
      inpr_q  <= inpr_d;
      outr_q  <= outr_d;
    end
  end

  always_comb begin
    fgi_d  = fgi_q;
    inpr_d = inpr_q;
    ovr_d  = ovr_q;
    // INP frees INPR in the same cycle, so a coincident character is accepted.
    if (op_inp) fgi_d = 1'b0;
    if (kb_valid) begin
      if (!fgi_q || op_inp) begin
        inpr_d = kb_data;
        fgi_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    fgo_d  = fgo_q;
    outr_d = outr_q;
    if (op_out) begin
      outr_d = ac_lo;
      fgo_d  = 1'b0;
    end else if (prn_ack && !fgo_q) begin
      fgo_d = 1'b1;
    end
  end

  always_comb begin
    ien_d   = ien_q;
    r_d     = r_q;
    state_d = state_q;
    if (op_iof)      ien_d = 1'b0;
    else if (op_ion) ien_d = 1'b1;
    if (ien_q && (fgi_q || fgo_q) && !fetch_busy && state_q == IDLE) r_d = 1'b1;
    unique case (state_q)
      IDLE: if (instr_boundary && r_q) state_d = RT0;
      RT0:  state_d = RT1;
      RT1:  state_d = RT2;
      RT2: begin
        ien_d   = 1'b0;
        r_d     = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fgi            = fgi_q;
  assign fgo            = fgo_q;
  assign ien            = ien_q;
  assign r_flag         = r_q;
  assign inpr           = inpr_q;
  assign outr           = outr_q;
  assign kb_overrun     = ovr_q;
  assign prn_req        = ~fgo_q;
  assign ac_load_inpr   = op_inp;
  assign skip_pc        = (op_ski & fgi_q) | (op_sko & fgo_q);
  assign irq_active     = (state_q != IDLE);
  assign irq_ar_load    = (state_q == RT0);
  assign irq_tr_load_pc = (state_q == RT0);
  assign irq_mem_write  = (state_q == RT1);
  assign irq_pc_load    = (state_q == RT1);
  assign irq_ar_value   = ADDR_W'(RET_ADDR);
  assign irq_pc_value   = ADDR_W'(ISR_ADDR);

endmodule

// File: tb/tb_bc_io_interrupt_ctrl.sv
// Directed bench for bc_io_interrupt_ctrl: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_bc_io_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_exec;
  logic [5:0]  io_op;
  logic [7:0]  ac_lo;
  logic        fetch_busy;
  logic        instr_boundary;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        prn_ack;
  logic        fgi, fgo, ien, r_flag, prn_req, ac_load_inpr, skip_pc;
  logic [7:0]  inpr, outr;
  logic        irq_active, irq_ar_load, irq_tr_load_pc, irq_mem_write, irq_pc_load;
  logic [11:0] irq_ar_value, irq_pc_value;
  logic        kb_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bc_io_interrupt_ctrl dut (
    .clk(clk), .rst(rst), .io_exec(io_exec), .io_op(io_op), .ac_lo(ac_lo),
    .fetch_busy(fetch_busy), .instr_boundary(instr_boundary),
    .kb_valid(kb_valid), .kb_data(kb_data), .prn_ack(prn_ack),
    .fgi(fgi), .fgo(fgo), .ien(ien), .r_flag(r_flag), .inpr(inpr), .outr(outr),
    .prn_req(prn_req), .ac_load_inpr(ac_load_inpr), .skip_pc(skip_pc),
    .irq_active(irq_active), .irq_ar_load(irq_ar_load), .irq_ar_value(irq_ar_value),
    .irq_tr_load_pc(irq_tr_load_pc), .irq_mem_write(irq_mem_write),
    .irq_pc_load(irq_pc_load), .irq_pc_value(irq_pc_value), .kb_overrun(kb_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic io(input logic [5:0] op);
    io_exec = 1'b1;
    io_op   = op;
  endtask

  task automatic idle_inputs();
    io_exec = 1'b0; io_op = '0; kb_valid = 1'b0; prn_ack = 1'b0; instr_boundary = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ac_lo = '0; kb_data = '0; fetch_busy = 1'b1;
    idle_inputs();
    repeat (2) step();
    check("rst_fgi", fgi, 0);
    check("rst_fgo", fgo, 1);
    check("rst_ien", ien, 0);
    check("rst_r", r_flag, 0);
    check("rst_inpr", inpr, 0);
    check("rst_outr", outr, 0);
    check("rst_ovr", kb_overrun, 0);
    check("rst_irq_active", irq_active, 0);
    check("rst_prn_req", prn_req, 0);
    rst = 1'b0;
    step();

    // Keyboard load and overrun
    kb_valid = 1'b1; kb_data = 8'h41; step(); idle_inputs();
    check("kb_inpr", inpr, 8'h41);
    check("kb_fgi", fgi, 1);
    check("kb_ovr0", kb_overrun, 0);
    kb_valid = 1'b1; kb_data = 8'h42; step(); idle_inputs();
    check("kb2_inpr", inpr, 8'h41);
    check("kb2_ovr", kb_overrun, 1);
    io(6'b001000); #1;
    check("ski_fgi1", skip_pc, 1);
    io(6'b100000); #1;
    check("inp_ac_load", ac_load_inpr, 1);
    check("inp_skip0", skip_pc, 0);
    step(); idle_inputs(); #1;
    check("inp_fgi", fgi, 0);
    check("inp_ac_load_off", ac_load_inpr, 0);
    io(6'b001000); #1;
    check("ski_fgi0", skip_pc, 0);
    idle_inputs();

    // INP with a coincident character keeps FGI set
    kb_valid = 1'b1; kb_data = 8'h43; step(); idle_inputs();
    io(6'b100000); kb_valid = 1'b1; kb_data = 8'h44; step(); idle_inputs();
    check("inp_kb_inpr", inpr, 8'h44);
    check("inp_kb_fgi", fgi, 1);
    check("ovr_sticky", kb_overrun, 1);

    // Output handshake
    io(6'b010000); ac_lo = 8'h5A; step(); idle_inputs();
    check("out_outr", outr, 8'h5A);
    check("out_fgo", fgo, 0);
    check("out_prn_req", prn_req, 1);
    io(6'b000100); #1;
    check("sko_busy", skip_pc, 0);
    idle_inputs();
    prn_ack = 1'b1; step(); idle_inputs();
    check("ack_fgo", fgo, 1);
    io(6'b000100); #1;
    check("sko_ready", skip_pc, 1);
    idle_inputs();
    // OUT beats a same-cycle acknowledge
    io(6'b010000); ac_lo = 8'h33; prn_ack = 1'b1; step(); idle_inputs();
    check("out_vs_ack_fgo", fgo, 0);
    check("out_vs_ack_outr", outr, 8'h33);
    prn_ack = 1'b1; step(); idle_inputs();
    check("ack2_fgo", fgo, 1);

    // ION/IOF, fetch_busy still high so R cannot set
    io(6'b000010); step(); idle_inputs();
    check("ion_ien", ien, 1);
    io(6'b000011); step(); idle_inputs();
    check("ion_iof_ien", ien, 0);

    // Fetch hold-off
    io(6'b000010); step(); idle_inputs();
    repeat (2) step();
    check("holdoff_r", r_flag, 0);
    fetch_busy = 1'b0; #1;
    check("holdoff_r_pre", r_flag, 0);
    step();
    check("holdoff_r_set", r_flag, 1);

    // Interrupt cycle
    instr_boundary = 1'b1; step(); idle_inputs();
    check("rt0_active", irq_active, 1);
    check("rt0_ar_load", irq_ar_load, 1);
    check("rt0_ar_value", irq_ar_value, 0);
    check("rt0_tr_load", irq_tr_load_pc, 1);
    check("rt0_mem_write", irq_mem_write, 0);
    step();
    check("rt1_mem_write", irq_mem_write, 1);
    check("rt1_pc_load", irq_pc_load, 1);
    check("rt1_pc_value", irq_pc_value, 1);
    check("rt1_ar_load", irq_ar_load, 0);
    step();
    check("rt2_active", irq_active, 1);
    check("rt2_pc_load", irq_pc_load, 0);
    step();
    check("post_active", irq_active, 0);
    check("post_ien", ien, 0);
    check("post_r", r_flag, 0);

    // Reset in the middle of RT1
    io(6'b000010); step(); idle_inputs();
    step();
    check("re_r_set", r_flag, 1);
    instr_boundary = 1'b1; step(); idle_inputs();
    step();
    check("re_rt1", irq_mem_write, 1);
    io(6'b010000); ac_lo = 8'h77; io_exec = 1'b0;
    rst = 1'b1; #1;
    check("abort_active", irq_active, 0);
    check("abort_mem_write", irq_mem_write, 0);
    check("abort_pc_load", irq_pc_load, 0);
    check("abort_fgo", fgo, 1);
    check("abort_ien", ien, 0);
    check("abort_r", r_flag, 0);
    check("abort_inpr", inpr, 0);
    step();
    rst = 1'b0; idle_inputs();
    step();
    check("after_rst_active", irq_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bc_io_interrupt_ctrl.md
Name: bc_io_interrupt_ctrl

Overview:
- Owns the Basic Computer's I/O and interrupt state: FGI/FGO flags, INPR/OUTR character registers, IEN and the R (interrupt-pending) flip-flop.
- Decodes and executes register-I/O instructions (INP, OUT, SKI, SKO, ION, IOF).
- Sequences the three-step interrupt cycle by emitting control strobes to the datapath in place of the controller.
- Sits beside the main controller; the controller yields the datapath while irq_active is high.

Parameters:
- CHAR_W, 8, width of INPR/OUTR and device data.
- ADDR_W, 12, width of AR/PC values driven during the interrupt cycle.
- RET_ADDR, 0, memory address that receives the return PC.
- ISR_ADDR, 1, PC value loaded at the end of the interrupt cycle.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_exec  in  1  controller: I/O instruction (D7 & I) is at T3 this cycle.
- io_op  in  6  IR[11:6]: bit5 INP, bit4 OUT, bit3 SKI, bit2 SKO, bit1 ION, bit0 IOF.
- ac_lo  in  CHAR_W  AC[7:0], source for OUT.
- fetch_busy  in  1  controller is in T0, T1 or T2.
- instr_boundary  in  1  controller is about to start a new fetch (SC=0).
- kb_valid  in  1  keyboard presents a character (single-cycle pulse).
- kb_data  in  CHAR_W  keyboard character.
- prn_ack  in  1  printer consumed OUTR (single-cycle pulse).
- fgi  out  1  input flag.
- fgo  out  1  output flag (1 = OUTR empty/ready).
- ien  out  1  interrupt enable.
- r_flag  out  1  interrupt pending.
- inpr  out  CHAR_W  input register.
- outr  out  CHAR_W  output register.
- prn_req  out  1  = ~fgo; OUTR holds an unprinted character.
- ac_load_inpr  out  1  datapath: AC[7:0] <= inpr (combinational, INP).
- skip_pc  out  1  datapath: PC <= PC+1 (combinational, SKI/SKO).
- irq_active  out  1  interrupt cycle in progress (RT0..RT2).
- irq_ar_load  out  1  AR <= irq_ar_value.
- irq_ar_value  out  ADDR_W  constant RET_ADDR.
- irq_tr_load_pc  out  1  TR <= PC.
- irq_mem_write  out  1  M[AR] <= TR.
- irq_pc_load  out  1  PC <= irq_pc_value.
- irq_pc_value  out  ADDR_W  constant ISR_ADDR.
- kb_overrun  out  1  sticky: character arrived while fgi=1.

Behaviour:
- Reset values: fgi=0, fgo=1, ien=0, r_flag=0, inpr=0, outr=0, kb_overrun=0, FSM=IDLE. All strobes are 0.
- Reset mid-interrupt-cycle aborts the cycle immediately.
- Keyboard: kb_valid & ~fgi -> inpr<=kb_data, fgi<=1. kb_valid & fgi -> character dropped, kb_overrun<=1. kb_overrun clears only on rst.
- Printer: prn_ack & ~fgo -> fgo<=1. prn_ack while fgo=1 is ignored.
- I/O instruction, active only when io_exec=1. Multiple op bits set apply together.
  - INP: ac_load_inpr=1 same cycle; fgi<=0 at the edge. If kb_valid arrives in the same cycle, the new char loads inpr and fgi stays 1.
  - OUT: outr<=ac_lo, fgo<=0. This takes precedence over a same-cycle prn_ack.
  - SKI/SKO: skip_pc = (SKI & fgi) | (SKO & fgo), using the pre-edge flag values.
  - ION -> ien<=1. IOF -> ien<=0. ION and IOF together -> IOF wins.
- R set: at an edge with ien & (fgi|fgo) & ~fetch_busy & ~irq_active -> r_flag<=1. Once set, it stays set until RT2 even if the flags drop.
- FSM, one state per cycle:
  - IDLE: instr_boundary & r_flag -> RT0; otherwise stay.
  - RT0: irq_active, irq_ar_load, irq_tr_load_pc; -> RT1.
  - RT1: irq_active, irq_mem_write, irq_pc_load; -> RT2.
  - RT2: irq_active; ien<=0, r_flag<=0; -> IDLE.
- Latency: instr_boundary with R=1 at edge k gives RT0 in cycle k+1 and IDLE again at k+4. The controller fetches from ISR_ADDR on the next instr_boundary.
- io_exec is ignored while irq_active; the controller guarantees it never coincides.

Test Plan:
- Reset check: assert rst mid-RT1 -> all strobes 0 the same cycle; fgo=1, ien=0, r_flag=0.
- Keyboard load: kb_valid with kb_data=0x41 -> inpr=0x41, fgi=1. Second kb_valid with 0x42 -> inpr stays 0x41, kb_overrun=1. INP -> ac_load_inpr=1, then fgi=0.
- Output handshake: OUT with ac_lo=0x5A -> outr=0x5A, fgo=0, prn_req=1. SKO -> skip_pc=0. prn_ack -> fgo=1. SKO -> skip_pc=1.
- ION/IOF clash: ION alone -> ien=1. io_op=000011 (ION+IOF) -> ien=0.
- Interrupt cycle: ien=1, fgi=1, fetch_busy=0 -> r_flag=1. instr_boundary -> RT0 (ar_load, value 0; tr_load_pc), RT1 (mem_write; pc_load, value 1), RT2 -> ien=0, r_flag=0, irq_active low afterward.
- Fetch hold-off: ien=1, fgo=1 while fetch_busy=1 -> r_flag stays 0 until fetch_busy falls. Then it sets on the next edge.
